// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON) on the MEM-stage data bus.
// Define UART_IRQ_EN to add the irq output and writable interrupt enables CON[1:0].
module uart_mmio #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] ADDR_TXD     = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD     = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON     = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic w_hit_txd, w_hit_rxd, w_hit_con;
  logic w_wr_txd, w_rd_rxd, w_rd_con;
  logic [1:0] w_ie;
  logic w_unused_wdata;

  assign w_hit_txd = (Address == ADDR_TXD);
  assign w_hit_rxd = (Address == ADDR_RXD);
  assign w_hit_con = (Address == ADDR_CON);
  assign w_rd_rxd  = MemRead && w_hit_rxd;
  assign w_rd_con  = MemRead && w_hit_con;
  assign w_unused_wdata = ^Write_data[31:8];

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic [7:0]    r_txd;
  logic          r_tx_busy;
  logic          r_tx_done;
  logic          r_tx_line;

  assign w_wr_txd = MemWrite && w_hit_txd && !r_tx_busy;
  assign uart_tx  = r_tx_line;

  // A CON read clears tx_done first; a completing stop bit in the same cycle overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_txd      <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      if (w_rd_con) r_tx_done <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_wr_txd) begin
            r_txd      <= Write_data[7:0];
            r_tx_shift <= Write_data[7:0];
            r_tx_busy  <= 1'b1;
            r_tx_line  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        default: begin
          if (r_tx_cnt != BIT_LAST) begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
              TX_START: begin
                r_tx_line  <= r_tx_shift[0];
                r_tx_idx   <= '0;
                r_tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (r_tx_idx == 3'd7) begin
                  r_tx_line  <= 1'b1;
                  r_tx_state <= TX_STOP;
                end else begin
                  r_tx_line  <= r_tx_shift[1];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_idx   <= r_tx_idx + 3'd1;
                end
              end
              TX_STOP: begin
                r_tx_busy  <= 1'b0;
                r_tx_done  <= 1'b1;
                r_tx_state <= TX_IDLE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rxd;
  logic          r_rx_ready;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;

  // Synchroniser flops reset to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rxd      <= '0;
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (w_rd_rxd || w_rd_con) r_rx_ready <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != HALF_LAST) begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end else begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != BIT_LAST) begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end else begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_idx   <= r_rx_idx + 3'd1;
            if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt != BIT_LAST) begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end else begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              r_rxd      <= r_rx_shift;
              r_rx_ready <= 1'b1;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_IRQ_EN
  logic [1:0] r_ie;
  logic       w_wr_con;

  assign w_wr_con = MemWrite && w_hit_con;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_ie <= 2'b00;
    else if (w_wr_con) r_ie <= Write_data[1:0];
  end

  assign w_ie = r_ie;
  assign irq  = (r_ie[0] & r_tx_done) | (r_ie[1] & r_rx_ready);
`else
  assign w_ie = 2'b00;
`endif

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (w_hit_txd)      Read_data = {24'h0, r_txd};
      else if (w_hit_rxd) Read_data = {24'h0, r_rxd};
      else if (w_hit_con) Read_data = {27'h0, r_tx_busy, r_rx_ready, r_tx_done, w_ie};
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at 16 clocks per bit: register table, TX/RX frames, flag corner cases.
module tb_uart_mmio;
  localparam int          CPB   = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
`ifdef UART_IRQ_EN
  localparam logic [31:0] IE_RD = 32'h3;
`else
  localparam logic [31:0] IE_RD = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] d;
  logic [7:0]  b;
  int hits;

  always #5 clk = ~clk;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
`ifdef UART_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected line level of bit slot k of an 8N1 frame carrying byte v.
  function automatic logic frame_bit(input logic [7:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return v[k-1];
  endfunction

  task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
    @(negedge clk);
    Address = a; MemRead = 1'b1;
    #1 data = Read_data;
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    Address = a; Write_data = wd; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Combinational look at a register with the strobe dropped before the next edge.
  task automatic peek(input logic [31:0] a, output logic [31:0] data);
    Address = a; MemRead = 1'b1;
    #1 data = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rx = (k == 9) ? stop : frame_bit(v, k);
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{A_TXD,         1'b1, 1'b0, 32'h0,  32'h0, "rst_txd"};
    vecs[1] = '{A_RXD,         1'b1, 1'b0, 32'h0,  32'h0, "rst_rxd"};
    vecs[2] = '{A_CON,         1'b1, 1'b0, 32'h0,  32'h0, "rst_con"};
    vecs[3] = '{A_CON,         1'b0, 1'b0, 32'h0,  32'h0, "no_strobe"};
    vecs[4] = '{32'h4000_0024, 1'b1, 1'b0, 32'h0,  32'h0, "unmapped"};
    vecs[5] = '{32'h5000_0018, 1'b1, 1'b0, 32'h0,  32'h0, "full_addr_cmp"};
    vecs[6] = '{A_CON,         1'b0, 1'b1, 32'h1F, 32'h0, "con_write"};
    vecs[7] = '{A_CON,         1'b1, 1'b0, 32'h0,  IE_RD, "con_ie_bits"};
    vecs[8] = '{A_CON,         1'b1, 1'b1, 32'h0,  IE_RD, "con_rw_same"};
    vecs[9] = '{A_CON,         1'b1, 1'b0, 32'h0,  32'h0, "con_cleared"};

    repeat (3) @(negedge clk);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Address = vecs[i].addr; MemRead = vecs[i].rd;
      MemWrite = vecs[i].wr; Write_data = vecs[i].wdata;
      #1 chk(vecs[i].name, Read_data, vecs[i].exp);
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;

    // TX of 0xA5 with a CON read and an ignored store in mid-frame
    bus_write(A_TXD, 32'h0000_00A5);
    fork
      begin
        repeat (7) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          chk("tx_a5_bit", {31'b0, uart_tx}, {31'b0, frame_bit(8'hA5, k)});
          if (k < 9) repeat (CPB) @(negedge clk);
        end
      end
      begin
        repeat (20) @(negedge clk);
        bus_read(A_CON, d);
        chk("con_busy", d, 32'h10);
        bus_write(A_TXD, 32'h0000_003C);
        bus_read(A_TXD, d);
        chk("txd_busy_ignored", d, 32'hA5);
      end
    join
    repeat (8) @(negedge clk);
    peek(A_CON, d);
    chk("stop_bit_still_busy", d, 32'h10);
    bus_read(A_CON, d);
    chk("con_tx_done", d, 32'h04);
    bus_read(A_CON, d);
    chk("con_done_cleared", d, 32'h0);

    // Random back-to-back TX frames
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(A_TXD, {24'h0, b});
      repeat (7) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        chk("tx_rand_bit", {31'b0, uart_tx}, {31'b0, frame_bit(b, k)});
        if (k < 9) repeat (CPB) @(negedge clk);
      end
      bus_read(A_TXD, d);
      chk("tx_rand_txd", d, {24'h0, b});
      repeat (6) @(negedge clk);
    end
    bus_read(A_CON, d);
    chk("tx_rand_done", d, 32'h04);

    // RX of 0x5A with timing window on rx_ready
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(negedge clk);
        repeat (152) @(negedge clk);
        peek(A_CON, d);
        chk("rx_ready_early", {31'b0, d[3]}, 32'h0);
        repeat (4) @(negedge clk);
        peek(A_CON, d);
        chk("rx_ready_set", {31'b0, d[3]}, 32'h1);
      end
    join
    bus_read(A_RXD, d);
    chk("rxd_5a", d, 32'h5A);
    peek(A_CON, d);
    chk("rx_ready_cleared", d, 32'h0);

    send_frame(8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    peek(A_CON, d);
    chk("framing_no_ready", d, 32'h0);
    @(negedge clk);
    peek(A_RXD, d);
    chk("framing_rxd_kept", d, 32'h5A);

    @(negedge clk);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    peek(A_CON, d);
    chk("glitch_ignored", d, 32'h0);

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    peek(A_CON, d);
    chk("overrun_ready", d, 32'h08);
    bus_read(A_RXD, d);
    chk("overrun_rxd", d, 32'h22);

    // Continuous CON reads across completion: the set must be seen exactly once
    hits = 0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (149) @(negedge clk);
        Address = A_CON; MemRead = 1'b1;
        for (int k = 0; k < 10; k++) begin
          #1 if (Read_data[3]) hits++;
          @(negedge clk);
        end
        MemRead = 1'b0;
      end
    join
    chk("set_wins_over_clear", hits, 32'd1);
    bus_read(A_RXD, d);
    chk("rxd_77", d, 32'h77);

    // Random RX frames against a last-byte model
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      bus_read(A_RXD, d);
      chk("rx_rand_rxd", d, {24'h0, b});
    end

`ifdef UART_IRQ_EN
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'h5C);
    repeat (165) @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_read(A_CON, d);
    chk("irq_con", d, 32'h07);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
`endif

    // Asynchronous reset in mid-frame
    bus_write(A_TXD, 32'h0);
    repeat (40) @(negedge clk);
    chk("tx_mid_low", {31'b0, uart_tx}, 32'h0);
    #1 reset = 1'b0;
    #1 chk("reset_tx_high", {31'b0, uart_tx}, 32'h1);
    peek(A_CON, d);
    chk("reset_con", d, 32'h0);
    @(negedge clk);
    peek(A_TXD, d);
    chk("reset_txd", d, 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {31'b0, uart_tx}, 32'h1);
`ifdef UART_IRQ_EN
    chk("post_reset_irq", {31'b0, irq}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
